// File: rtl/e_pkg.sv
// Shared definitions for the e-computation arbiter: word width, counter width and FSM states.
package e_pkg;

  localparam int unsigned WORD_W = 16;
  // Wide enough for MUL_LAT-1 with MUL_LAT up to 15.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/e_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo NREQ.
module e_rr_pick #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = IDX_W'((32'(ptr) + off) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    any = found;
  end

endmodule

// File: rtl/e_multi_arbiter.sv
// Round-robin arbiter sharing one multi-word multiplier between NREQ requesters:
// grant, wait MUL_LAT cycles, then hold the full product until the owner takes it.
module e_multi_arbiter
  import e_pkg::*;
#(
  parameter int unsigned WORDS   = 32,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ*WORD_W*WORDS-1:0]   req_a,
  input  logic [NREQ*WORD_W*WORDS-1:0]   req_b,
  output logic [NREQ-1:0]                rsp_valid,
  input  logic [NREQ-1:0]                rsp_ready,
  output logic [2*WORD_W*WORDS-1:0]      rsp_data,
  output logic [WORD_W*WORDS-1:0]        mul_a,
  output logic [WORD_W*WORDS-1:0]        mul_b,
  input  logic [2*WORD_W*WORDS-1:0]      mul_out,
  output logic                           busy
);

  localparam int unsigned OP_W  = WORD_W * WORDS;
  localparam int unsigned IDX_W = $clog2(NREQ);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  pick_gnt;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [OP_W-1:0]  sel_a;
  logic [OP_W-1:0]  sel_b;
  logic [IDX_W-1:0] ptr_next;

  e_rr_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(pick_gnt),
    .any(pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = IDX_W'(i);
      end
    end
  end

  assign sel_a    = req_a[32'(pick_idx)*OP_W +: OP_W];
  assign sel_b    = req_b[32'(pick_idx)*OP_W +: OP_W];
  assign ptr_next = IDX_W'((32'(gnt) + 32'd1) % NREQ);

  // Gated by rst_n so a handshake can never appear to complete on a reset edge.
  assign req_ready = (state == IDLE && rst_n) ? pick_gnt : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) begin
      rsp_valid[gnt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      rsp_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
            gnt   <= pick_idx;
            cnt   <= CNT_W'(MUL_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data <= mul_out;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_multi_arbiter.sv
// Self-checking bench for e_multi_arbiter: directed table, corner sequences, random vs model.
module tb_e_multi_arbiter;

  localparam int unsigned WORDS   = 32;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned OP_W    = 16 * WORDS;
  localparam int unsigned PR_W    = 2 * OP_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*OP_W-1:0]   req_a;
  logic [NREQ*OP_W-1:0]   req_b;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [PR_W-1:0]        rsp_data;
  logic [OP_W-1:0]        mul_a;
  logic [OP_W-1:0]        mul_b;
  logic [PR_W-1:0]        mul_out;
  logic                   busy;

  e_multi_arbiter #(
    .WORDS(WORDS),
    .NREQ(NREQ),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_out(mul_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in with MUL_LAT-1 = 2 register stages.
  logic [PR_W-1:0] pipe1, pipe2;
  always @(posedge clk) begin
    pipe1 <= PR_W'(mul_a) * PR_W'(mul_b);
    pipe2 <= pipe1;
  end
  assign mul_out = pipe2;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [PR_W-1:0] act, input logic [PR_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
               act[PR_W-1 -: 128], act[127:0], exp[PR_W-1 -: 128], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    req_a[i*OP_W +: OP_W] = a;
    req_b[i*OP_W +: OP_W] = b;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (MUL_LAT + 2) tick();
    rsp_ready = '0;
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] v;
    v = '0;
    case ($urandom_range(3))
      0: v = '1;
      1: v = OP_W'($urandom_range(1000));
      default: for (int k = 0; k < OP_W / 32; k++) v[k*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [NREQ-1:0] gnt;
    logic [PR_W-1:0] prod;
  } vec_t;

  vec_t tbl[9];

  // Transaction-level reference: 0 idle, 1 computing, 2 response offered.
  int              m_phase, m_owner, m_left, m_ptr;
  logic [OP_W-1:0] m_a, m_b;
  logic [PR_W-1:0] m_prod;

  function automatic int model_pick();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: summary not reached in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NREQ-1:0] exp_rdy, exp_rv, hs;
    int              g;
    int              gr_idx[$];
    int              gr_cyc[$];
    int              exp_order[5];

    exp_order = '{0, 1, 2, 3, 0};
    tbl[0] = '{valid: 4'b0001, a: OP_W'(3), b: OP_W'(5), gnt: 4'b0001, prod: PR_W'(15)};
    tbl[1] = '{valid: 4'b0001, a: OP_W'(7), b: OP_W'(11), gnt: 4'b0001, prod: PR_W'(77)};
    tbl[2] = '{valid: 4'b1001, a: OP_W'(100), b: OP_W'(200), gnt: 4'b1000, prod: PR_W'(20000)};
    tbl[3] = '{valid: 4'b1110, a: OP_W'(16'hFFFF), b: OP_W'(16'hFFFF), gnt: 4'b0010,
               prod: PR_W'(32'hFFFE_0001)};
    tbl[4] = '{valid: 4'b0011, a: OP_W'(0), b: OP_W'(12345), gnt: 4'b0001, prod: PR_W'(0)};
    tbl[5] = '{valid: 4'b1111, a: {OP_W{1'b1}}, b: {OP_W{1'b1}}, gnt: 4'b0010,
               prod: {{(OP_W-1){1'b1}}, {OP_W{1'b0}}, 1'b1}};
    tbl[6] = '{valid: 4'b1011, a: OP_W'(64'h1_0000_0000), b: OP_W'(64'h1_0000_0000),
               gnt: 4'b1000, prod: PR_W'(128'h1_0000_0000_0000_0000)};
    tbl[7] = '{valid: 4'b1100, a: OP_W'(9), b: OP_W'(9), gnt: 4'b0100, prod: PR_W'(81)};
    tbl[8] = '{valid: 4'b0110, a: OP_W'(6), b: OP_W'(7), gnt: 4'b0010, prod: PR_W'(42)};

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset req_ready", PR_W'(req_ready), PR_W'(0));
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("reset busy", PR_W'(busy), PR_W'(0));
    chk("reset rsp_valid", PR_W'(rsp_valid), PR_W'(0));
    chk("reset mul_a", PR_W'(mul_a), PR_W'(0));
    chk("reset mul_b", PR_W'(mul_b), PR_W'(0));
    chk("reset rsp_data", rsp_data, PR_W'(0));
    tick();

    // Directed table: one operation per entry, rotating pointer hand-tracked from reset.
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].valid;
      rsp_ready = '0;
      for (int j = 0; j < NREQ; j++) begin
        if (tbl[i].gnt[j]) set_op(j, tbl[i].a, tbl[i].b);
        else set_op(j, rand_op(), rand_op());
      end
      @(negedge clk);
      chk("tbl grant", PR_W'(req_ready), PR_W'(tbl[i].gnt));
      chk("tbl idle busy", PR_W'(busy), PR_W'(0));
      tick();
      req_valid = '0;
      for (int k = 1; k <= MUL_LAT; k++) begin
        @(negedge clk);
        chk("tbl early rsp_valid", PR_W'(rsp_valid), PR_W'(0));
        chk("tbl wait busy", PR_W'(busy), PR_W'(1));
        if (k == 1) begin
          chk("tbl mul_a", PR_W'(mul_a), PR_W'(tbl[i].a));
          chk("tbl mul_b", PR_W'(mul_b), PR_W'(tbl[i].b));
        end
        tick();
      end
      @(negedge clk);
      chk("tbl rsp_valid", PR_W'(rsp_valid), PR_W'(tbl[i].gnt));
      chk("tbl rsp_data", rsp_data, tbl[i].prod);
      chk("tbl resp req_ready", PR_W'(req_ready), PR_W'(0));
      rsp_ready = '1;
      tick();
      rsp_ready = '0;
      @(negedge clk);
      chk("tbl back idle", PR_W'(busy), PR_W'(0));
      chk("tbl rsp dropped", PR_W'(rsp_valid), PR_W'(0));
      tick();
    end

    // Fairness: all valid, rsp_ready high, from a freshly reset pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_op(i, OP_W'(i + 1), OP_W'(10));
    req_valid = '1;
    rsp_ready = '1;
    for (int cyc = 0; cyc < 40 && gr_idx.size() < 5; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) chk("fair rsp_data", rsp_data, PR_W'((i + 1) * 10));
        if (req_ready[i]) begin
          gr_idx.push_back(i);
          gr_cyc.push_back(cyc);
        end
      end
      tick();
    end
    chk("fair grant count", PR_W'(gr_idx.size()), PR_W'(5));
    for (int k = 0; k < gr_idx.size() && k < 5; k++) begin
      chk("fair order", PR_W'(gr_idx[k]), PR_W'(exp_order[k]));
      if (k > 0) chk("fair spacing", PR_W'(gr_cyc[k] - gr_cyc[k-1]), PR_W'(MUL_LAT + 2));
    end
    drain();
    @(negedge clk);
    chk("fair drained", PR_W'(busy), PR_W'(0));
    tick();

    // Response stall on requester 1 with others waiting; pointer is 1 here.
    req_valid = 4'b0010;
    set_op(1, OP_W'(13), OP_W'(17));
    @(negedge clk);
    chk("stall grant", PR_W'(req_ready), PR_W'(4'b0010));
    tick();
    req_valid = 4'b0101;
    set_op(0, OP_W'(2), OP_W'(3));
    set_op(2, OP_W'(19), OP_W'(23));
    repeat (MUL_LAT) begin
      @(negedge clk);
      chk("stall wait ready", PR_W'(req_ready), PR_W'(0));
      tick();
    end
    rsp_ready = 4'b1101;
    repeat (10) begin
      @(negedge clk);
      chk("stall rsp_valid", PR_W'(rsp_valid), PR_W'(4'b0010));
      chk("stall rsp_data", rsp_data, PR_W'(221));
      chk("stall req_ready", PR_W'(req_ready), PR_W'(0));
      tick();
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    chk("stall release", PR_W'(rsp_valid), PR_W'(4'b0010));
    tick();
    rsp_ready = '0;
    @(negedge clk);
    chk("stall next grant", PR_W'(req_ready), PR_W'(4'b0100));
    tick();
    drain();

    // Reset pulse during WAIT; pointer is 3 before it.
    req_valid = 4'b1000;
    set_op(3, OP_W'(5), OP_W'(5));
    @(negedge clk);
    chk("rstwait grant", PR_W'(req_ready), PR_W'(4'b1000));
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("rstwait busy before", PR_W'(busy), PR_W'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstwait busy", PR_W'(busy), PR_W'(0));
    chk("rstwait req_ready", PR_W'(req_ready), PR_W'(0));
    chk("rstwait mul_a", PR_W'(mul_a), PR_W'(0));
    repeat (MUL_LAT + 2) begin
      @(negedge clk);
      chk("rstwait no rsp", PR_W'(rsp_valid), PR_W'(0));
      tick();
    end
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, OP_W'(i + 2), OP_W'(3));
    @(negedge clk);
    chk("rstwait fresh grant", PR_W'(req_ready), PR_W'(4'b0001));
    tick();
    drain();

    // Reset and request in the same cycle: reset wins.
    req_valid = 4'b0010;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst+req ready", PR_W'(req_ready), PR_W'(0));
    tick();
    rst_n = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("rst+req busy", PR_W'(busy), PR_W'(0));
    chk("rst+req mul_a", PR_W'(mul_a), PR_W'(0));
    tick();

    // Requester 0 pulses valid while a response is pending, then withdraws.
    req_valid = 4'b0100;
    set_op(2, OP_W'(4), OP_W'(4));
    @(negedge clk);
    chk("wd grant", PR_W'(req_ready), PR_W'(4'b0100));
    tick();
    req_valid = '0;
    repeat (MUL_LAT) tick();
    req_valid = 4'b0001;
    @(negedge clk);
    chk("wd pending rsp", PR_W'(rsp_valid), PR_W'(4'b0100));
    chk("wd no ready", PR_W'(req_ready), PR_W'(0));
    tick();
    req_valid = '0;
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    repeat (6) begin
      @(negedge clk);
      chk("wd never granted", PR_W'(req_ready), PR_W'(0));
      chk("wd never served", PR_W'(rsp_valid), PR_W'(0));
      chk("wd idle", PR_W'(busy), PR_W'(0));
      tick();
    end

    // Random traffic against the transaction model, starting from reset.
    rst_n = 1'b0;
    tick();
    m_phase = 0; m_owner = 0; m_left = 0; m_ptr = 0; m_a = '0; m_b = '0; m_prod = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(99) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(2) == 0) begin
            req_valid[i] = 1'b1;
            set_op(i, rand_op(), rand_op());
          end
        end else if ($urandom_range(19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = NREQ'($urandom);
      @(negedge clk);
      g = model_pick();
      exp_rdy = (m_phase == 0 && rst_n && g >= 0) ? (NREQ'(1) << g) : '0;
      exp_rv  = (m_phase == 2) ? (NREQ'(1) << m_owner) : '0;
      chk("rnd req_ready", PR_W'(req_ready), PR_W'(exp_rdy));
      chk("rnd rsp_valid", PR_W'(rsp_valid), PR_W'(exp_rv));
      chk("rnd busy", PR_W'(busy), PR_W'(m_phase != 0));
      chk("rnd mul_a", PR_W'(mul_a), PR_W'(m_a));
      chk("rnd mul_b", PR_W'(mul_b), PR_W'(m_b));
      if (m_phase == 2) chk("rnd rsp_data", rsp_data, m_prod);
      hs = req_ready;
      if (!rst_n) begin
        m_phase = 0; m_ptr = 0; m_a = '0; m_b = '0;
      end else if (m_phase == 0) begin
        if (g >= 0) begin
          m_phase = 1; m_owner = g; m_left = MUL_LAT;
          m_a = req_a[g*OP_W +: OP_W];
          m_b = req_b[g*OP_W +: OP_W];
          m_prod = PR_W'(m_a) * PR_W'(m_b);
        end
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else if (rsp_ready[m_owner]) begin
        m_phase = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end
      tick();
      for (int i = 0; i < NREQ; i++) if (hs[i]) req_valid[i] = 1'b0;
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
